// File: rtl/approx_err_monitor_pkg.sv
// approx_err_monitor_pkg: shared state encoding, widths and parameter-check helper
package approx_err_monitor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam int PROD_W = 16;
  localparam int ERR_W = 17;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/approx_err_monitor_err_dist_pipe.sv
// err_dist_pipe: two-stage exact product then signed/absolute error distance, valid passthrough
module err_dist_pipe
  import approx_err_monitor_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic [7:0]               i_a,
  input  logic [7:0]               i_b,
  input  logic [PROD_W-1:0]        i_approx,
  output logic                     o_s1_valid,
  output logic                     o_valid,
  output logic signed [ERR_W-1:0]  o_d,
  output logic [PROD_W-1:0]        o_ed,
  output logic                     o_neq
);
  logic r_v1, r_v2, r_neq;
  logic [PROD_W-1:0] r_exact, r_approx, r_ed;
  logic signed [ERR_W-1:0] r_d;
  logic [ERR_W-1:0] w_d;
  // 17-bit difference keeps the sign; |d| tops out at 65535 so it fits 16 bits exactly
  assign w_d = {1'b0, r_approx} - {1'b0, r_exact};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_exact <= '0;
      r_approx <= '0;
      r_d <= '0;
      r_ed <= '0;
      r_neq <= 1'b0;
    end else begin
      r_v1 <= i_valid & ~i_clr;
      r_exact <= {8'd0, i_a} * {8'd0, i_b};
      r_approx <= i_approx;
      r_v2 <= r_v1 & ~i_clr;
      r_d <= w_d;
      r_ed <= w_d[ERR_W-1] ? PROD_W'(-w_d) : w_d[PROD_W-1:0];
      r_neq <= |w_d;
    end
  assign o_s1_valid = r_v1;
  assign o_valid = r_v2;
  assign o_d = r_d;
  assign o_ed = r_ed;
  assign o_neq = r_neq;
endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: windowed error statistics for an 8x8 approximate multiplier
module approx_err_monitor
  import approx_err_monitor_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int CW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  a,
  input  logic [7:0]                  b,
  input  logic [PROD_W-1:0]           approx_r,
  output logic                        busy,
  output logic                        done,
  output logic [CW:0]                 err_cnt,
  output logic [PROD_W+CW-1:0]        sum_ed,
  output logic [PROD_W-1:0]           max_ed,
  output logic signed [ERR_W+CW-1:0]  sum_err
);
  if (N_SAMPLES < 1 || N_SAMPLES > 65535 || clog2(N_SAMPLES) > CW) begin : g_bad_param
    $error("approx_err_monitor: N_SAMPLES does not fit CW");
  end
  state_t r_state, w_next;
  logic r_done;
  logic [CW:0] r_cnt, r_err_cnt;
  logic [PROD_W+CW-1:0] r_sum_ed;
  logic [PROD_W-1:0] r_max_ed, w_ed;
  logic signed [ERR_W+CW-1:0] r_sum_err;
  logic signed [ERR_W-1:0] w_d;
  logic w_acc, w_clr, w_last, w_s1v, w_pv, w_neq;
  assign in_ready = r_state == RUN;
  assign busy = r_state == RUN || r_state == DRAIN;
  assign done = r_done;
  assign w_acc = in_valid & in_ready;
  assign w_clr = start & (r_state == IDLE || r_state == DONE);
  assign w_last = w_acc & (r_cnt == (CW+1)'(N_SAMPLES - 1));
  err_dist_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_valid    (w_acc),
    .i_a        (a),
    .i_b        (b),
    .i_approx   (approx_r),
    .o_s1_valid (w_s1v),
    .o_valid    (w_pv),
    .o_d        (w_d),
    .o_ed       (w_ed),
    .o_neq      (w_neq)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == DRAIN && w_next == DONE;
    end
  // DRAIN ends when the final sample sits in stage 2 with nothing behind it
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? RUN : r_state;
      RUN:        w_next = w_last ? DRAIN : RUN;
      DRAIN:      w_next = (w_pv & ~w_s1v) ? DONE : DRAIN;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst || w_clr) begin
      r_cnt <= '0;
      r_err_cnt <= '0;
      r_sum_ed <= '0;
      r_max_ed <= '0;
      r_sum_err <= '0;
    end else begin
      if (w_acc) r_cnt <= r_cnt + (CW+1)'(1);
      if (w_pv) begin
        r_err_cnt <= r_err_cnt + (CW+1)'(w_neq);
        r_sum_ed <= r_sum_ed + (PROD_W+CW)'(w_ed);
        r_sum_err <= r_sum_err + (ERR_W+CW)'(w_d);
        r_max_ed <= w_ed > r_max_ed ? w_ed : r_max_ed;
      end
    end
  assign err_cnt = r_err_cnt;
  assign sum_ed = r_sum_ed;
  assign max_ed = r_max_ed;
  assign sum_err = r_sum_err;
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: four monitors with N_SAMPLES=1..4 checked against an arithmetic error model
module tb_approx_err_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start [4];
  logic in_valid;
  logic [7:0] a, b;
  logic [15:0] approx_r;
  logic in_ready [4];
  logic busy [4];
  logic done [4];
  logic [8:0] err_cnt [4];
  logic [23:0] sum_ed [4];
  logic [15:0] max_ed [4];
  logic signed [24:0] sum_err [4];
  for (genvar k = 0; k < 4; k++) begin : g_dut
    approx_err_monitor #(.N_SAMPLES(k + 1), .CW(8)) u_dut (
      .clk(clk), .rst(rst), .start(start[k]), .in_valid(in_valid), .in_ready(in_ready[k]),
      .a(a), .b(b), .approx_r(approx_r), .busy(busy[k]), .done(done[k]),
      .err_cnt(err_cnt[k]), .sum_ed(sum_ed[k]), .max_ed(max_ed[k]), .sum_err(sum_err[k])
    );
  end
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] sa [8];
  logic [7:0] sb [8];
  logic [15:0] sr [8];
  int gp [8];

  // mode 0: exact, 1: exact+5, 2: mixed random errors including approx=65535 with exact=0
  task automatic fill(input int mode, input int n);
    int p, q, r;
    for (int i = 0; i < n; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      p = int'(sa[i]) * int'(sb[i]);
      q = p + int'($urandom_range(0, 600)) - 300;
      q = q < 0 ? 0 : (q > 65535 ? 65535 : q);
      r = int'($urandom_range(0, 3));
      sr[i] = mode == 0 ? 16'(p) : mode == 1 ? 16'(p + 5) :
              r == 0 ? 16'(p) : r == 1 ? 16'($urandom) : 16'(q);
      if (mode == 2 && r == 3) begin
        sa[i] = 8'd0;
        sr[i] = 16'hFFFF;
      end
      gp[i] = int'($urandom_range(0, 3));
    end
  endtask

  task automatic run_window(input int k, input string nm, input bit pre_started, input bit rude, input bit chain);
    int ec, sed, mx, se, d, ad;
    ec = 0; sed = 0; mx = 0; se = 0;
    if (!pre_started) begin
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
    end
    total_cnt++;
    if (in_ready[k] !== 1'b1 || busy[k] !== 1'b1 || err_cnt[k] !== 9'd0 || sum_ed[k] !== 24'd0 || max_ed[k] !== 16'd0 || sum_err[k] !== 25'd0)
      $display("FAIL %s run_entry got ready=%b busy=%b err_cnt=%0d sum_ed=%0d max_ed=%0d sum_err=%0d exp ready=1 busy=1 stats=0",
               nm, in_ready[k], busy[k], err_cnt[k], sum_ed[k], max_ed[k], sum_err[k]);
    else pass_cnt++;
    for (int i = 0; i <= k; i++) begin
      for (int g = 0; g < gp[i]; g++) begin
        in_valid = 1'b0;
        a = 8'($urandom);
        start[k] = rude;
        @(negedge clk);
        start[k] = 1'b0;
      end
      in_valid = 1'b1; a = sa[i]; b = sb[i]; approx_r = sr[i];
      total_cnt++;
      if (in_ready[k] !== 1'b1) $display("FAIL %s accept%0d got ready=%b exp 1", nm, i, in_ready[k]);
      else pass_cnt++;
      d = int'(sr[i]) - int'(sa[i]) * int'(sb[i]);
      ad = d < 0 ? -d : d;
      ec += (d != 0) ? 1 : 0;
      sed += ad;
      mx = ad > mx ? ad : mx;
      se += d;
      @(negedge clk);
    end
    for (int c = 1; c <= 4; c++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); approx_r = 16'($urandom);
      start[k] = rude && c == 1;
      total_cnt++;
      if (in_ready[k] !== 1'b0 || done[k] !== (c == 3) || busy[k] !== (c < 3))
        $display("FAIL %s ctl c=%0d got ready=%b done=%b busy=%b exp ready=0 done=%b busy=%b",
                 nm, c, in_ready[k], done[k], busy[k], c == 3, c < 3);
      else pass_cnt++;
      if (c >= 3) begin
        total_cnt++;
        if (err_cnt[k] !== 9'(ec)) $display("FAIL %s err_cnt c=%0d got %0d exp %0d", nm, c, err_cnt[k], ec);
        else pass_cnt++;
        total_cnt++;
        if (sum_ed[k] !== 24'(sed)) $display("FAIL %s sum_ed c=%0d got %0d exp %0d", nm, c, sum_ed[k], sed);
        else pass_cnt++;
        total_cnt++;
        if (max_ed[k] !== 16'(mx)) $display("FAIL %s max_ed c=%0d got %0d exp %0d", nm, c, max_ed[k], mx);
        else pass_cnt++;
        total_cnt++;
        if (sum_err[k] !== 25'(se)) $display("FAIL %s sum_err c=%0d got %0d exp %0d", nm, c, sum_err[k], se);
        else pass_cnt++;
      end
      if (c == 3 && chain) begin
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      start[k] = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (in_ready[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 || err_cnt[k] !== 9'd0 || sum_ed[k] !== 24'd0 || max_ed[k] !== 16'd0 || sum_err[k] !== 25'd0)
        $display("FAIL reset inst%0d got ready=%b busy=%b done=%b err_cnt=%0d sum_ed=%0d max_ed=%0d sum_err=%0d exp all 0",
                 k, in_ready[k], busy[k], done[k], err_cnt[k], sum_ed[k], max_ed[k], sum_err[k]);
      else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exact;
    fill(0, 4);
    sa[0] = 8'd3;   sb[0] = 8'd5;   sr[0] = 16'd15;
    sa[1] = 8'd255; sb[1] = 8'd255; sr[1] = 16'd65025;
    sa[2] = 8'd0;   sb[2] = 8'd7;   sr[2] = 16'd0;
    sa[3] = 8'd16;  sb[3] = 8'd16;  sr[3] = 16'd256;
    run_window(3, "exact", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_const_err;
    fill(1, 4);
    run_window(3, "plus5", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_extremes;
    sa[0] = 8'd255; sb[0] = 8'd255; sr[0] = 16'd0;     gp[0] = 0;
    sa[1] = 8'd1;   sb[1] = 8'd1;   sr[1] = 16'd3;     gp[1] = 1;
    run_window(1, "extremes", 1'b0, 1'b0, 1'b0);
    sa[0] = 8'd0;   sb[0] = 8'd200; sr[0] = 16'hFFFF;  gp[0] = 0;
    sa[1] = 8'd0;   sb[1] = 8'd9;   sr[1] = 16'hFFFF;  gp[1] = 0;
    run_window(1, "ed_max", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single;
    fill(2, 1);
    run_window(0, "n1", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_start;
    fill(2, 3);
    gp[0] = 0; gp[1] = 2; gp[2] = 5;
    run_window(2, "gaps", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    in_valid = 1'b1; a = 8'd3; b = 8'd3; approx_r = 16'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (err_cnt[3] !== 9'd1 || busy[3] !== 1'b1) $display("FAIL pre_reset got err_cnt=%0d busy=%b exp err_cnt=1 busy=1", err_cnt[3], busy[3]);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (in_ready[3] !== 1'b0 || busy[3] !== 1'b0 || done[3] !== 1'b0 || err_cnt[3] !== 9'd0 || sum_ed[3] !== 24'd0 || max_ed[3] !== 16'd0 || sum_err[3] !== 25'd0)
      $display("FAIL async_reset got ready=%b busy=%b done=%b err_cnt=%0d sum_ed=%0d max_ed=%0d sum_err=%0d exp all 0",
               in_ready[3], busy[3], done[3], err_cnt[3], sum_ed[3], max_ed[3], sum_err[3]);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(0, 4);
    run_window(3, "post_reset", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    fill(2, 4);
    run_window(3, "b2b_first", 1'b0, 1'b0, 1'b1);
    fill(1, 4);
    run_window(3, "b2b_second", 1'b1, 1'b0, 1'b1);
    fill(2, 4);
    run_window(3, "b2b_third", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    int k;
    for (int rep = 0; rep < 8; rep++) begin
      k = int'($urandom_range(0, 3));
      fill(2, k + 1);
      run_window(k, "random", 1'b0, rep[0], 1'b0);
    end
  endtask

  initial begin
    foreach (start[i]) start[i] = 1'b0;
    in_valid = 1'b0; a = 8'd0; b = 8'd0; approx_r = 16'd0;
    test_reset;
    test_exact;
    test_const_err;
    test_extremes;
    test_single;
    test_gaps_start;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
